// File: rtl/writeback_if.sv
// M-to-W pipeline bundle: the memory-stage fields captured by the writeback stage.
interface writeback_if #(
  parameter int unsigned WIDTH = 8
);
  logic             ValidM;
  logic             RegWriteM;
  logic             MemtoRegM;
  logic             LoadByteM;
  logic             PCSrcM;
  logic [3:0]       WA3M;
  logic [WIDTH-1:0] ALUOutM;
  logic [WIDTH-1:0] ReadDataM;

  modport master (
    output ValidM, RegWriteM, MemtoRegM, LoadByteM, PCSrcM, WA3M, ALUOutM, ReadDataM
  );

  modport slave (
    input ValidM, RegWriteM, MemtoRegM, LoadByteM, PCSrcM, WA3M, ALUOutM, ReadDataM
  );
endinterface

// File: rtl/writeback_stage.sv
// Writeback stage: M/W pipeline register, result select, R15 redirect and retire counter.
// Optional W-to-D same-cycle operand bypass enabled by defining WB_DECODE_BYPASS_EN.
module writeback_stage #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 StallW,
  input  logic                 FlushW,
  writeback_if.slave           m_if,
  input  logic [3:0]           RA1D,
  input  logic [3:0]           RA2D,
  input  logic [WIDTH-1:0]     RD1,
  input  logic [WIDTH-1:0]     RD2,
  output logic                 RegWriteW,
  output logic                 PCSrcW,
  output logic [3:0]           WA3W,
  output logic [WIDTH-1:0]     ResultW,
  output logic [WIDTH-1:0]     RD1D,
  output logic [WIDTH-1:0]     RD2D,
  output logic [CNT_WIDTH-1:0] RetireCount
);

  localparam logic [3:0] PC_REG = 4'd15;

  typedef struct packed {
    logic             valid;
    logic             reg_write;
    logic             mem_to_reg;
    logic             load_byte;
    logic             pc_src;
    logic [3:0]       wa3;
    logic [WIDTH-1:0] alu_out;
    logic [WIDTH-1:0] read_data;
  } w_reg_t;

  w_reg_t               w_q, w_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  // Flush beats stall; write enables are gated by ValidM at capture.
  always_comb begin
    w_d   = w_q;
    cnt_d = cnt_q;
    if (FlushW) begin
      w_d = '0;
    end else if (!StallW) begin
      w_d.valid      = m_if.ValidM;
      w_d.reg_write  = m_if.RegWriteM & m_if.ValidM;
      w_d.mem_to_reg = m_if.MemtoRegM;
      w_d.load_byte  = m_if.LoadByteM;
      w_d.pc_src     = m_if.PCSrcM & m_if.ValidM;
      w_d.wa3        = m_if.WA3M;
      w_d.alu_out    = m_if.ALUOutM;
      w_d.read_data  = m_if.ReadDataM;
      if (m_if.ValidM) cnt_d = cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      w_q   <= '0;
      cnt_q <= '0;
    end else begin
      w_q   <= w_d;
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    ResultW = w_q.alu_out;
    if (w_q.mem_to_reg) begin
      ResultW = w_q.load_byte ? WIDTH'(w_q.read_data[7:0]) : w_q.read_data;
    end
  end

  assign RegWriteW   = w_q.reg_write;
  assign PCSrcW      = w_q.pc_src;
  assign WA3W        = w_q.wa3;
  assign RetireCount = cnt_q;

`ifdef WB_DECODE_BYPASS_EN
  // R15 reads come from the PC path in decode, so it is never bypassed.
  assign RD1D = (w_q.reg_write && (w_q.wa3 == RA1D) && (RA1D != PC_REG)) ? ResultW : RD1;
  assign RD2D = (w_q.reg_write && (w_q.wa3 == RA2D) && (RA2D != PC_REG)) ? ResultW : RD2;

  logic unused_w;
  assign unused_w = w_q.valid;
`else
  assign RD1D = RD1;
  assign RD2D = RD2;

  logic unused_w;
  assign unused_w = ^{w_q.valid, RA1D, RA2D, PC_REG};
`endif

endmodule

// File: doc/writeback_stage.md
# writeback_stage

Final (W) stage of the pipelined core and the write side of the register file interface that the decode stage reads. It holds the memory-to-writeback pipeline register and selects the write-back result (ALU output, word load or zero-extended byte load). It drives `RegWriteW`, `WA3W` and `ResultW` to the register file, raises `PCSrcW` for writes to R15, and keeps a retired-instruction counter. An optional same-cycle bypass returns the value being written to decode's read ports.

## Interface
Parameters:
- `WIDTH`, 8: datapath width. Must be ≥ 8.
- `CNT_WIDTH`, 16: width of the retired-instruction counter.

Ports:
- `clk`  in  1  clock. All state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `StallW`  in  1  hold the W register.
- `FlushW`  in  1  insert a bubble into W.
- `ValidM`  in  1  M stage holds a real instruction.
- `RegWriteM`  in  1  instruction writes a register.
- `MemtoRegM`  in  1  result comes from memory, not the ALU.
- `LoadByteM`  in  1  memory result is a byte load.
- `PCSrcM`  in  1  instruction writes R15 (branch or PC load).
- `WA3M`  in  4  destination register.
- `ALUOutM`  in  WIDTH  ALU result.
- `ReadDataM`  in  WIDTH  data memory read data.
- `RA1D`, `RA2D`  in  4 each  decode read addresses.
- `RD1`, `RD2`  in  WIDTH each  raw register file read data.
- `RegWriteW`  out  1  register file write enable (`we3`).
- `PCSrcW`  out  1  PC redirect from W.
- `WA3W`  out  4  register file write address (`ra3`).
- `ResultW`  out  WIDTH  register file write data (`wd3`).
- `RD1D`, `RD2D`  out  WIDTH each  decode operands, possibly bypassed.
- `RetireCount`  out  CNT_WIDTH  number of instructions captured into W.

## Operation
- **W register fields:** `ValidW`, `RegWriteW`, `MemtoRegW`, `LoadByteW`, `PCSrcW`, `WA3W`, `ALUOutW`, `ReadDataW`.
- **Update priority, evaluated at each edge:**
  - `reset`: all fields and `RetireCount` become 0.
  - else `FlushW`: all fields become 0. `RetireCount` holds.
  - else `StallW`: all fields hold. `RetireCount` holds.
  - else: load every field from its M counterpart. If `ValidM`=1, `RetireCount` increments.
- **Gating at capture:** `RegWriteW` is loaded with `RegWriteM & ValidM` and `PCSrcW` with `PCSrcM & ValidM`, so a non-valid instruction can never write.
- **ResultW (combinational from W fields):**
  - `MemtoRegW`=0: `ALUOutW`.
  - `MemtoRegW`=1, `LoadByteW`=0: `ReadDataW`.
  - `MemtoRegW`=1, `LoadByteW`=1: zero-extended `ReadDataW[7:0]`.
  - `LoadByteW` is ignored when `MemtoRegW`=0.
- **RetireCount:** unsigned, wraps from all-ones to 0 with no flag.
- **RD1D/RD2D:** see Configuration.

## Timing
- Latency: M inputs appear on the W outputs 1 cycle after a non-stalled, non-flushed edge.
- The register file writes `ResultW` on the next edge while `RegWriteW`=1.
- **Reset values:** `RegWriteW`=0, `PCSrcW`=0, `WA3W`=0, `ResultW`=0, `RetireCount`=0. `RD1D`/`RD2D` follow `RD1`/`RD2`.
- **Simultaneous events:**
  - `FlushW` and `StallW` together: flush wins.
  - `reset` with anything: reset wins.
  - Reset in mid-stall discards the held instruction.
- **Stall:** a held instruction keeps `RegWriteW` high for every stalled cycle. The register file rewrites the same value each cycle, which is harmless.
- **Stall release:** while `StallW` is held, M is not captured. The held instruction retires on the release edge.
- **R15 as destination:** `WA3W`=15 with `RegWriteW`=1 is legal and is signalled by `PCSrcW`. `PCSrcW` is a single-cycle output unless W is stalled.

## Configuration
- Macro: `WB_DECODE_BYPASS_EN`.
- **Defined:**
  - `RD1D` = `ResultW` when `RegWriteW`=1, `WA3W`==`RA1D` and `RA1D`≠15; otherwise `RD1`.
  - `RD2D` follows the same rule using `RA2D` and `RD2`.
  - Purely combinational. Resolves the W-to-D same-cycle hazard without a falling-edge register file write.
- **Undefined:** `RD1D`=`RD1` and `RD2D`=`RD2` unconditionally. The hazard unit must stall decode on a W/D address match.

## Test plan
- **ALU write:** `ValidM`=1, `RegWriteM`=1, `MemtoRegM`=0, `WA3M`=3, `ALUOutM`=0x5A, then one edge → `RegWriteW`=1, `WA3W`=3, `ResultW`=0x5A, `RetireCount`=1.
- **Byte load:** `WIDTH`=32, `MemtoRegM`=1, `LoadByteM`=1, `ReadDataM`=0x1234ABCD, then edge → `ResultW`=0x000000CD. Same stimulus with `LoadByteM`=0 → `ResultW`=0x1234ABCD.
- **Stall and flush:**
  - Capture `WA3M`=4, then `StallW`=1 for 3 cycles while M changes → W outputs unchanged and `RetireCount` unchanged.
  - `FlushW`=1 and `StallW`=1 together → `RegWriteW`=0 next cycle.
- **PC write and invalid slot:**
  - `WA3M`=15, `RegWriteM`=1, `PCSrcM`=1 → `PCSrcW`=1 for exactly 1 cycle.
  - `ValidM`=0 with `RegWriteM`=1 → `RegWriteW`=0.
- **Counter and reset:**
  - `CNT_WIDTH`=4: 17 valid captures → `RetireCount`=1 (wrap).
  - Assert `reset` mid-run → all outputs 0 at the next edge.
- **Bypass:**
  - Defined: `RegWriteW`=1, `WA3W`=2, `ResultW`=0x77, `RA1D`=2, `RD1`=0x11 → `RD1D`=0x77. With `RA1D`=15 → `RD1D`=`RD1`.
  - Undefined: `RD1D`=0x11 for the same stimulus.
